ball_move_ctrl: RTL

- Per-frame movement scheduler for the labyrinth ball.
- On each game tick it latches the debounced direction buttons and checks each requested step against the map through a shared map-lookup port. It then issues one-cycle movement pulses to the Ball block, for permitted directions only.
- Sits between the debounce module and Ball.
- Replaces the top-level tick counters and the button-AND-tick gating.

---
 rtl/ball_pkg.sv | 44 ++++
 rtl/tick_gen.sv | 31 +++
 rtl/ball_move_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ball_pkg.sv
// Shared definitions for the ball movement path: direction indices, scheduler
// states, screen limits and small direction helpers.
package ball_pkg;

    localparam int DIR_UP = 0;
    localparam int DIR_DN = 1;
    localparam int DIR_LT = 2;
    localparam int DIR_RT = 3;

    localparam int SCR_X_MAX = 639;
    localparam int SCR_Y_MAX = 479;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        REQ,
        WAIT,
        EVAL,
        ISSUE
    } move_state_t;

    // Opposing requests on one axis cancel each other: neither moves nor blocks.
    function automatic logic [3:0] cancel_opposites(input logic [3:0] d);
        logic [3:0] r;
        r = d;
        if (d[DIR_UP] && d[DIR_DN]) begin
            r[DIR_UP] = 1'b0;
            r[DIR_DN] = 1'b0;
        end
        if (d[DIR_LT] && d[DIR_RT]) begin
            r[DIR_LT] = 1'b0;
            r[DIR_RT] = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [1:0] lowest_dir(input logic [3:0] p);
        if (p[DIR_UP]) return 2'(DIR_UP);
        if (p[DIR_DN]) return 2'(DIR_DN);
        if (p[DIR_LT]) return 2'(DIR_LT);
        return 2'(DIR_RT);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running rate divider: one-cycle tick every CLK_HZ/TICK_HZ clocks,
// asserted in the cycle the counter sits at its terminal value.
module tick_gen #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 30
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int PERIOD = CLK_HZ / TICK_HZ;
    localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (cnt == CW'(PERIOD - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CW'(PERIOD - 1));

endmodule

// File: rtl/ball_move_ctrl.sv
// Per-tick ball movement scheduler: latches direction requests, checks each
// step against bounds and the shared map port, then pulses permitted moves.
module ball_move_ctrl
    import ball_pkg::*;
#(
    parameter int         CLK_HZ    = 100_000_000,
    parameter int         TICK_HZ   = 30,
    parameter int         MAP_LAT   = 2,
    parameter int         STEP      = 1,
    parameter int         X_MAX     = SCR_X_MAX,
    parameter int         Y_MAX     = SCR_Y_MAX,
    parameter logic [7:0] WALL_MASK = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] dir_req,
    input  logic [9:0] loc_x,
    input  logic [8:0] loc_y,
    output logic       map_req,
    output logic [9:0] map_x,
    output logic [8:0] map_y,
    input  logic       map_gnt,
    input  logic [7:0] map_data,
    output logic [3:0] movement,
    output logic [3:0] blocked,
    output logic       busy,
    output logic       tick_miss
);

    localparam logic [10:0] STEP_X = 11'(STEP);
    localparam logic [9:0]  STEP_Y = 10'(STEP);
    localparam logic [10:0] XMAX_W = 11'(X_MAX);
    localparam logic [9:0]  YMAX_W = 10'(Y_MAX);

    logic        tick;
    move_state_t state;
    logic [3:0]  pend;
    logic [3:0]  go;
    logic [1:0]  cur;
    logic [2:0]  lat_cnt;
    logic [7:0]  data_q;

    logic [1:0]  cur_sel;
    logic        tgt_ok;
    logic [9:0]  tgt_x;
    logic [8:0]  tgt_y;
    logic [10:0] x_w;
    logic [9:0]  y_w;
    logic [3:0]  cur_bit;
    logic        wall_hit;
    logic [3:0]  pend_clr;
    logic [3:0]  go_next;
    logic [3:0]  dir_eff;

    tick_gen #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    assign x_w     = {1'b0, loc_x};
    assign y_w     = {1'b0, loc_y};
    assign dir_eff = cancel_opposites(dir_req);

    // Widened sums keep the bound test free of wrap-around at the screen edges.
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        cur_sel = lowest_dir(pend);
        tgt_ok  = 1'b0;
        tgt_x   = loc_x;
        tgt_y   = loc_y;
        case (cur_sel)
            2'(DIR_UP): begin
                tgt_ok = (y_w >= STEP_Y);
                tgt_y  = 9'(y_w - STEP_Y);
            end
            2'(DIR_DN): begin
                tgt_ok = (y_w + STEP_Y <= YMAX_W);
                tgt_y  = 9'(y_w + STEP_Y);
            end
            2'(DIR_LT): begin
                tgt_ok = (x_w >= STEP_X);
                tgt_x  = 10'(x_w - STEP_X);
            end
            default: begin
                tgt_ok = (x_w + STEP_X <= XMAX_W);
                tgt_x  = 10'(x_w + STEP_X);
            end
        endcase
    end

    assign cur_bit  = 4'b0001 << cur;
    assign wall_hit = |(data_q & WALL_MASK);
    assign pend_clr = pend & ~cur_bit;
    assign go_next  = wall_hit ? go : (go | cur_bit);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pend      <= '0;
            go        <= '0;
            cur       <= '0;
            lat_cnt   <= '0;
            data_q    <= '0;
            map_req   <= 1'b0;
            map_x     <= '0;
            map_y     <= '0;
            movement  <= '0;
            blocked   <= '0;
            tick_miss <= 1'b0;
        end else begin
            movement <= '0;
            if (tick && state != IDLE) begin
                tick_miss <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tick && dir_req != 4'b0000) begin
                        pend    <= dir_eff;
                        go      <= '0;
                        blocked <= '0;
                        state   <= (dir_eff == 4'b0000) ? ISSUE : SEL;
                    end
                end
                SEL: begin
                    if (pend == 4'b0000) begin
                        movement <= go;
                        state    <= ISSUE;
                    end else begin
                        cur <= cur_sel;
                        if (tgt_ok) begin
                            map_req <= 1'b1;
                            map_x   <= tgt_x;
                            map_y   <= tgt_y;
                            state   <= REQ;
                        end else begin
                            blocked[cur_sel] <= 1'b1;
                            pend[cur_sel]    <= 1'b0;
                        end
                    end
                end
                REQ: begin
                    if (map_gnt) begin
                        map_req <= 1'b0;
                        lat_cnt <= 3'd1;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == 3'(MAP_LAT)) begin
                        data_q <= map_data;
                        state  <= EVAL;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                EVAL: begin
                    if (wall_hit) begin
                        blocked[cur] <= 1'b1;
                    end
                    go   <= go_next;
                    pend <= pend_clr;
                    // Last pending direction goes straight to the pulse cycle.
                    if (pend_clr == 4'b0000) begin
                        movement <= go_next;
                        state    <= ISSUE;
                    end else begin
                        state <= SEL;
                    end
                end
                ISSUE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule
